// File: rtl/stim_sequencer_if.sv
// Host/DUT-facing bundle for stim_sequencer: opcode write port, run control,
// the replayed vector stream and the hit-capture result.
interface stim_sequencer_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) ();

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W:0]   wr_data;
  logic [ADDR_W:0]   length;
  logic              start;
  logic              stop;
  logic              loop;
  logic              dut_out;

  logic [DATA_W-1:0] in_out;
  logic              obs_out;
  logic              vec_valid;
  logic [ADDR_W-1:0] vec_idx;
  logic              busy;
  logic              done;
  logic              hit;
  logic [ADDR_W-1:0] hit_idx;

  modport master (
    output wr_en, wr_addr, wr_data, length, start, stop, loop, dut_out,
    input  in_out, obs_out, vec_valid, vec_idx, busy, done, hit, hit_idx
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, length, start, stop, loop, dut_out,
    output in_out, obs_out, vec_valid, vec_idx, busy, done, hit, hit_idx
  );

endinterface

// File: rtl/stim_sequencer.sv
// On-chip opcode player: replays stored {obs, byte} vectors into a DUT and
// records the first vector index at which the DUT output fires.
// Optional continuous replay is enabled by defining STIM_SEQUENCER_LOOP_EN.
module stim_sequencer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input logic clock,
  input logic reset,
  stim_sequencer_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Clamp a requested length to the memory depth and return the last index.
  function automatic logic [ADDR_W-1:0] last_index(input logic [ADDR_W:0] len);
    logic [ADDR_W:0] clipped;
    clipped = (len > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : len;
    return ADDR_W'(clipped - (ADDR_W+1)'(1));
  endfunction

  logic [DATA_W:0]   mem [DEPTH];

  logic [1:0]        state_p0;
  logic [ADDR_W-1:0] pc_p0;
  logic [ADDR_W-1:0] last_p0;

  logic [DATA_W-1:0] in_out_p1;
  logic              obs_p1;
  logic              vld_p1;
  logic [ADDR_W-1:0] vec_idx_p1;

  logic              hit_p2;
  logic [ADDR_W-1:0] hit_idx_p2;

  logic [DATA_W:0]   rd_word;
  logic              start_ok;
  logic              stop_ok;
  logic              at_last;
  logic              wrap;

  assign rd_word  = mem[pc_p0];
  assign start_ok = bus.start && !bus.stop && (state_p0 != ST_RUN) && (bus.length != '0);
  assign stop_ok  = bus.stop && (state_p0 != ST_IDLE);
  assign at_last  = (pc_p0 == last_p0);

`ifdef STIM_SEQUENCER_LOOP_EN
  assign wrap = bus.loop;
`else
  logic unused_loop;
  assign unused_loop = bus.loop;
  assign wrap        = 1'b0;
`endif

  // Opcode store: no reset, writes locked out while a run is replaying.
  always_ff @(posedge clock) begin
    if (bus.wr_en && (state_p0 != ST_RUN)) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_p0   <= ST_IDLE;
      pc_p0      <= '0;
      last_p0    <= '0;
      in_out_p1  <= '0;
      obs_p1     <= 1'b0;
      vld_p1     <= 1'b0;
      vec_idx_p1 <= '0;
      hit_p2     <= 1'b0;
      hit_idx_p2 <= '0;
    end else begin
      // stage p2: first-hit capture from the vector currently on the bus
      if (vld_p1 && bus.dut_out && !hit_p2) begin
        hit_p2     <= 1'b1;
        hit_idx_p2 <= vec_idx_p1;
      end

      // stage p0 -> p1: sequencing and registered vector output
      case (state_p0)
        ST_IDLE: begin
          vld_p1 <= 1'b0;
          if (start_ok) begin
            state_p0   <= ST_RUN;
            pc_p0      <= '0;
            last_p0    <= last_index(bus.length);
            hit_p2     <= 1'b0;
            hit_idx_p2 <= '0;
          end
        end

        ST_RUN: begin
          if (bus.stop) begin
            state_p0  <= ST_IDLE;
            pc_p0     <= '0;
            in_out_p1 <= '0;
            obs_p1    <= 1'b0;
            vld_p1    <= 1'b0;
          end else begin
            in_out_p1  <= rd_word[DATA_W-1:0];
            obs_p1     <= rd_word[DATA_W];
            vec_idx_p1 <= pc_p0;
            vld_p1     <= 1'b1;
            if (at_last) begin
              pc_p0 <= '0;
              if (!wrap) begin
                state_p0 <= ST_DONE;
              end
            end else begin
              pc_p0 <= pc_p0 + ADDR_W'(1);
            end
          end
        end

        ST_DONE: begin
          vld_p1 <= 1'b0;
          if (stop_ok) begin
            state_p0  <= ST_IDLE;
            pc_p0     <= '0;
            in_out_p1 <= '0;
            obs_p1    <= 1'b0;
          end else if (start_ok) begin
            state_p0   <= ST_RUN;
            pc_p0      <= '0;
            last_p0    <= last_index(bus.length);
            hit_p2     <= 1'b0;
            hit_idx_p2 <= '0;
          end
        end

        default: begin
          state_p0 <= ST_IDLE;
          pc_p0    <= '0;
          vld_p1   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_out    = in_out_p1;
  assign bus.obs_out   = obs_p1;
  assign bus.vec_valid = vld_p1;
  assign bus.vec_idx   = vec_idx_p1;
  assign bus.busy      = (state_p0 == ST_RUN);
  assign bus.done      = (state_p0 == ST_DONE);
  assign bus.hit       = hit_p2;
  assign bus.hit_idx   = hit_idx_p2;

endmodule

// File: tb/tb_stim_sequencer.sv
// Scoreboard bench for stim_sequencer: expected vectors are queued at launch
// from a local opcode model and retired by a negedge monitor.
module tb_stim_sequencer;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  typedef struct packed {
    logic              obs;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] idx;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  stim_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  stim_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   vld_count = 0;
  int   first_cyc = 0;
  int   last_cyc = 0;
  int   hit_lo = 1;
  int   hit_hi = 0;
  logic dut_force = 1'b0;
  logic [DATA_W:0] model_mem [DEPTH];
  exp_t exp_q [$];

  // Behavioural DUT: out fires while a vector inside [hit_lo, hit_hi] is driven.
  assign bus.dut_out = dut_force |
                       ((bus.vec_valid === 1'b1) &&
                        (int'(bus.vec_idx) >= hit_lo) && (int'(bus.vec_idx) <= hit_hi));

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (bus.vec_valid === 1'b1) begin
      exp_t e;
      vld_count++;
      if (vld_count == 1) first_cyc = cyc;
      last_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("vec_spurious", 32'(exp_q.size()), 1);
      end else begin
        e = exp_q.pop_front();
        chk("in_out",  32'(bus.in_out),  32'(e.data));
        chk("obs_out", 32'(bus.obs_out), 32'(e.obs));
        chk("vec_idx", 32'(bus.vec_idx), 32'(e.idx));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_op(input int addr, input logic [DATA_W:0] data, input bit upd);
    bus.wr_en   = 1'b1;
    bus.wr_addr = ADDR_W'(addr);
    bus.wr_data = data;
    tick();
    bus.wr_en = 1'b0;
    if (upd) model_mem[addr] = data;
  endtask

  // Queue npush expected vectors for a run of the given length, then pulse start.
  task automatic launch(input int len, input int npush);
    int eff;
    exp_t e;
    eff = (len > DEPTH) ? DEPTH : len;
    vld_count = 0;
    for (int i = 0; i < npush; i++) begin
      e.idx  = ADDR_W'(i % eff);
      e.obs  = model_mem[i % eff][DATA_W];
      e.data = model_mem[i % eff][DATA_W-1:0];
      exp_q.push_back(e);
    end
    bus.length = (ADDR_W+1)'(len);
    bus.start  = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!(bus.done === 1'b1 && bus.vec_valid === 1'b0) && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_timeout"}, 32'(n < 200), 1);
  endtask

  task automatic check_run(input string tag, input int n);
    chk({tag, "_count"},  32'(vld_count), 32'(n));
    chk({tag, "_contig"}, 32'(last_cyc - first_cyc + 1), 32'(n));
    chk({tag, "_drain"},  32'(exp_q.size()), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.length = '0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.loop = 1'b0;
    repeat (3) tick();

    chk("rst_busy",    32'(bus.busy), 0);
    chk("rst_done",    32'(bus.done), 0);
    chk("rst_valid",   32'(bus.vec_valid), 0);
    chk("rst_in_out",  32'(bus.in_out), 0);
    chk("rst_obs",     32'(bus.obs_out), 0);
    chk("rst_vec_idx", 32'(bus.vec_idx), 0);
    chk("rst_hit",     32'(bus.hit), 0);
    chk("rst_hit_idx", 32'(bus.hit_idx), 0);
    reset = 1'b0;
    tick();

    write_op(0, 9'h101, 1'b1);
    write_op(1, 9'h022, 1'b1);
    write_op(2, 9'h1FF, 1'b1);
    write_op(3, 9'h000, 1'b1);
    for (int i = 4; i < DEPTH; i++) write_op(i, {i[0], 8'(8'h40 + i)}, 1'b1);

    // Basic four-vector run with a single hit on vector 2.
    hit_lo = 2; hit_hi = 2;
    launch(4, 4);
    chk("run_busy", 32'(bus.busy), 1);
    wait_done("basic");
    check_run("basic", 4);
    chk("basic_done",    32'(bus.done), 1);
    chk("basic_hold",    32'(bus.in_out), 32'h00);
    chk("basic_hit",     32'(bus.hit), 1);
    chk("basic_hit_idx", 32'(bus.hit_idx), 2);

    // dut_out high outside any valid vector must not disturb the capture.
    dut_force = 1'b1;
    tick();
    dut_force = 1'b0;
    chk("late_hit_idx", 32'(bus.hit_idx), 2);

    // A fresh start clears the hit; the new first hit lands on vector 3.
    hit_lo = 3; hit_hi = 3;
    launch(4, 4);
    chk("restart_hit_clr", 32'(bus.hit), 0);
    wait_done("restart");
    check_run("restart", 4);
    chk("restart_hit_idx", 32'(bus.hit_idx), 3);
    hit_lo = 1; hit_hi = 0;

    // stop from DONE, then a zero-length start is ignored.
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk("stop_done_clr", 32'(bus.done), 0);
    launch(0, 0);
    repeat (4) tick();
    chk("len0_busy", 32'(bus.busy), 0);
    chk("len0_done", 32'(bus.done), 0);
    chk("len0_vld",  32'(vld_count), 0);

    // Oversized length is clamped to the memory depth.
    launch(20, DEPTH);
    wait_done("len20");
    check_run("len20", DEPTH);

    // stop sampled on the third RUN cycle: only vectors 0 and 1 get out.
    launch(8, 2);
    tick();
    tick();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk("stop_busy",   32'(bus.busy), 0);
    chk("stop_in_out", 32'(bus.in_out), 0);
    chk("stop_valid",  32'(bus.vec_valid), 0);
    repeat (3) tick();
    check_run("stop", 2);

    // Simultaneous start and stop from DONE: stop wins.
    launch(2, 2);
    wait_done("pre_ss");
    bus.length = 5'd4;
    bus.start  = 1'b1;
    bus.stop   = 1'b1;
    vld_count  = 0;
    tick();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    repeat (3) tick();
    chk("ss_busy", 32'(bus.busy), 0);
    chk("ss_done", 32'(bus.done), 0);
    chk("ss_vld",  32'(vld_count), 0);

    // Writes during RUN are dropped; the replay must still match the model.
    launch(4, 4);
    write_op(1, 9'h0AA, 1'b0);
    wait_done("wr_run");
    check_run("wr_run", 4);
    launch(4, 4);
    wait_done("wr_replay");
    check_run("wr_replay", 4);

    // Reset while vector 1 is on the bus.
    begin
      int n;
      launch(8, 2);
      n = 0;
      while (!(bus.vec_valid === 1'b1 && bus.vec_idx == 1) && n < 50) begin
        tick();
        n++;
      end
      chk("mid_rst_wait", 32'(n < 50), 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_rst_busy",   32'(bus.busy), 0);
      chk("mid_rst_valid",  32'(bus.vec_valid), 0);
      chk("mid_rst_in_out", 32'(bus.in_out), 0);
      chk("mid_rst_idx",    32'(bus.vec_idx), 0);
      repeat (3) tick();
      check_run("mid_rst", 2);
    end

`ifdef STIM_SEQUENCER_LOOP_EN
    // Looping two-vector run, loop dropped during the third pass's vector 0.
    begin
      int n;
      bus.loop = 1'b1;
      launch(2, 6);
      n = 0;
      while (!(bus.vec_valid === 1'b1 && bus.vec_idx == 0 && vld_count >= 4) && n < 50) begin
        tick();
        n++;
      end
      chk("loop_wait", 32'(n < 50), 1);
      chk("loop_busy", 32'(bus.busy), 1);
      bus.loop = 1'b0;
      wait_done("loop");
      check_run("loop", 6);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
